hwpe_stream_vec_alu: RTL and testbench
======================================

// Module: hwpe_stream_vec_alu
// PURPOSE
//  SIMD element-wise ALU between NB_OPERANDS stream sources (after TCDM load) and one stream sink.
//  Joins all operand streams: a beat fires only when every operand is valid.
//  Splits each beat into DATA_WIDTH/ELEM_WIDTH lanes and left-folds a runtime-selected op across operands.
//  Pipelines the result PIPE_STAGES deep with full backpressure; counts a job of len_i beats and flags done.
// PARAMETERS
//  DATA_WIDTH   32  stream data width in bits; multiple of ELEM_WIDTH and of 32
//  ELEM_WIDTH   32  lane width in bits: 8, 16 or 32
//  NB_OPERANDS  2   number of operand streams, >= 2
//  PIPE_STAGES  2   register stages from join to result, >= 1
//  LEN_WIDTH    16  width of the job length and beat counter
// PORTS
//  clk_i      in   1                     clock
//  rst_i      in   1                     asynchronous reset, active-high
//  clear_i    in   1                     synchronous soft clear
//  start_i    in   1                     job start pulse; sampled only in IDLE
//  op_i       in   3                     vec_op_t, latched at start
//  len_i      in   LEN_WIDTH             beats in the job, latched at start
//  operand_i  in   stream[NB_OPERANDS]   hwpe_stream_intf_stream.sink, DATA_WIDTH
//  result_o   out  stream                hwpe_stream_intf_stream.source, DATA_WIDTH
//  busy_o     out  1                     high in RUN and DRAIN
//  done_o     out  1                     one-cycle pulse at job end
//  count_o    out  LEN_WIDTH             result beats emitted in current/last job
// BEHAVIOUR
//  Reset (rst_i=1, async): FSM=IDLE; all stage valids, result_o.valid, operand ready, busy_o, done_o, count_o = 0.
//  Ops (vec_op_t): ADD, SUB, MUL (low ELEM_WIDTH bits), MIN_S, MAX_S, AND, OR, XOR.
//    Lane fold: r = op(...op(op(x0,x1),x2)...,xN-1). Arithmetic wraps modulo 2^ELEM_WIDTH; no carry between lanes.
//  result strb = bitwise AND of all operand strb, delayed with the data.
//  FSM:
//    IDLE  -> RUN on start_i when len_i != 0; latch op and len; clear count_o.
//    IDLE  -> done_o pulse next cycle on start_i with len_i == 0; FSM stays IDLE; no beats consumed.
//    RUN   -> DRAIN on the cycle the len-th beat is joined.
//    DRAIN -> IDLE once the pipeline is empty and the last beat has handshaken; done_o=1 that cycle.
//    start_i is ignored outside IDLE.
//  Join:
//    fire = (state==RUN) & all operand valid & stage0 can load.
//    operand_i[k].ready = fire for every k; no partial consumption and no ready-before-valid dependency.
//    Operand ready = 0 in IDLE and DRAIN; extra beats stay in the upstream FIFOs.
//  Pipeline:
//    Stage s loads when it is empty or stage s+1 loads; the last stage is freed by result_o handshake.
//    Bubbles collapse; throughput is 1 beat/cycle; latency fire -> result_o.valid = PIPE_STAGES cycles.
//    result_o.valid = last-stage valid; data/strb stable while valid & ~ready.
//  count_o increments on each result_o handshake; it holds its value after done until the next start.
//  clear_i: same effect as reset but synchronous; in-flight beats are dropped; done_o is not pulsed.
//  Simultaneous: the last join and the first result handshake in the same cycle are both legal; the count stays exact.
// STRUCTURE
//  Package hwpe_vec_alu_package: vec_op_t enum, VEC_OP_* constants, vec_alu_ctrl_t {op,len,start}, vec_alu_flags_t {busy,done,count}.
//  Sub-module hwpe_stream_vec_alu_lane: combinational ELEM_WIDTH two-input op.
//    Instantiated (NB_OPERANDS-1) x lanes as a fold chain before stage 0.
// TESTING
//  1 ADD, E=32, N=2, len=4; a={1,2,3,0xFFFFFFFF}, b={10,20,30,1}, result ready=1 -> {11,22,33,0}; done 2 cycles after last join; count=4.
//  2 E=8, DATA=32, MAX_S; a=0x7F80_0102, b=0x0081_FF01 -> 0x7F81_0102; SUB a=0x00000001, b=0x00000002 -> 0x000000FF in lane 0.
//  3 N=3, MUL; x0=3, x1=5, x2=7 -> 105; op0 valid at cycle 0, op2 valid at cycle 3 -> no ready before cycle 3, join at cycle 3.
//  4 Backpressure: len=8, result ready toggles 1010...; all 8 results in order, none duplicated; operand ready=0 while pipeline full & ~ready.
//  5 Edge: len=0 -> done_o pulse 1 cycle after start, no operand ready; start during RUN ignored; extra 9th operand beat not consumed.
//  6 clear_i mid-job (after 3 joins, PIPE_STAGES=2) -> next cycle busy_o=0, result valid=0, count=0, no done; new job of len=2 runs correctly.

Source files
------------

// File: rtl/hwpe_stream_vec_alu_pkg.sv
// Shared types for the SIMD element-wise stream ALU.
//   vec_op_t        : lane operation selector (3 bits)
//   vec_alu_state_t : control FSM states
//   vec_alu_ctrl_t  : {op, len, start} control bundle at the default length width
//   vec_alu_flags_t : {busy, done, count} status bundle at the default length width
package hwpe_vec_alu_package;

  typedef enum logic [2:0] {
    VEC_OP_ADD   = 3'd0,
    VEC_OP_SUB   = 3'd1,
    VEC_OP_MUL   = 3'd2,
    VEC_OP_MIN_S = 3'd3,
    VEC_OP_MAX_S = 3'd4,
    VEC_OP_AND   = 3'd5,
    VEC_OP_OR    = 3'd6,
    VEC_OP_XOR   = 3'd7
  } vec_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } vec_alu_state_t;

  localparam int unsigned VEC_ALU_LEN_WIDTH = 16;

  typedef struct packed {
    vec_op_t                        op;
    logic [VEC_ALU_LEN_WIDTH-1:0]   len;
    logic                           start;
  } vec_alu_ctrl_t;

  typedef struct packed {
    logic                           busy;
    logic                           done;
    logic [VEC_ALU_LEN_WIDTH-1:0]   count;
  } vec_alu_flags_t;

endpackage

// File: rtl/hwpe_stream_vec_alu_if.sv
// Valid/ready stream interface carrying a data word and its byte strobes.
//   valid, data, strb : driven by the source
//   ready             : driven by the sink
// source/sink and master/slave are equivalent modport pairs.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
  modport master (output valid, output data, output strb, input ready);
  modport slave  (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_vec_alu_lane.sv
// Combinational two-input lane operator, ELEM_WIDTH bits wide.
//   a, b : lane operands (a is the running fold value)
//   op   : operation select
//   res  : result, arithmetic wraps modulo 2^ELEM_WIDTH
module hwpe_stream_vec_alu_lane
  import hwpe_vec_alu_package::*;
#(
  parameter int unsigned ELEM_WIDTH = 32
) (
  input  logic [ELEM_WIDTH-1:0] a,
  input  logic [ELEM_WIDTH-1:0] b,
  input  vec_op_t               op,
  output logic [ELEM_WIDTH-1:0] res
);

  always_comb begin
    res = '0;
    case (op)
      VEC_OP_ADD:   res = a + b;
      VEC_OP_SUB:   res = a - b;
      VEC_OP_MUL:   res = a * b;
      VEC_OP_MIN_S: res = ($signed(a) < $signed(b)) ? a : b;
      VEC_OP_MAX_S: res = ($signed(a) > $signed(b)) ? a : b;
      VEC_OP_AND:   res = a & b;
      VEC_OP_OR:    res = a | b;
      VEC_OP_XOR:   res = a ^ b;
      default:      res = '0;
    endcase
  end

endmodule

// File: rtl/hwpe_stream_vec_alu.sv
// SIMD element-wise ALU: joins NB_OPERANDS operand streams, left-folds the selected op
// per lane, and emits results through a PIPE_STAGES-deep backpressured pipeline.
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   clear_i         : synchronous soft clear (drops in-flight beats, no done pulse)
//   start_i         : job start, only honoured in idle; op_i/len_i latched then
//   operand_i[k]    : operand stream sinks; all share one ready (joined)
//   result_o        : result stream source
//   busy_o          : job running or draining
//   done_o          : one-cycle pulse at job end
//   count_o         : result beats emitted in the current/last job
module hwpe_stream_vec_alu
  import hwpe_vec_alu_package::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ELEM_WIDTH  = 32,
  parameter int unsigned NB_OPERANDS = 2,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  vec_op_t                op_i,
  input  logic [LEN_WIDTH-1:0]   len_i,
  hwpe_stream_intf_stream.sink   operand_i [NB_OPERANDS],
  hwpe_stream_intf_stream.source result_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [LEN_WIDTH-1:0]   count_o
);

  localparam int unsigned NB_LANES   = DATA_WIDTH / ELEM_WIDTH;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // Control state
  vec_alu_state_t       state_q, state_d;
  vec_op_t              op_q, op_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] join_cnt_q, join_cnt_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic                 zero_done_q, zero_done_d;

  // Join
  logic [NB_OPERANDS-1:0] op_valid;
  logic [DATA_WIDTH-1:0]  op_data [NB_OPERANDS];
  logic [STRB_WIDTH-1:0]  op_strb [NB_OPERANDS];
  logic [DATA_WIDTH-1:0]  join_data;
  logic [STRB_WIDTH-1:0]  join_strb;
  logic                   fire;
  logic                   last_join;

  // Pipeline
  logic                  stage_valid_q [PIPE_STAGES];
  logic [DATA_WIDTH-1:0] stage_data_q  [PIPE_STAGES];
  logic [STRB_WIDTH-1:0] stage_strb_q  [PIPE_STAGES];
  logic                  stage_load    [PIPE_STAGES];
  logic                  stage_in_valid [PIPE_STAGES];
  logic [DATA_WIDTH-1:0] stage_in_data  [PIPE_STAGES];
  logic [STRB_WIDTH-1:0] stage_in_strb  [PIPE_STAGES];
  logic                  upstream_valid;
  logic                  result_hs;
  logic                  drain_done;

  for (genvar k = 0; k < NB_OPERANDS; k++) begin : g_operand
    assign op_valid[k]        = operand_i[k].valid;
    assign op_data[k]         = operand_i[k].data;
    assign op_strb[k]         = operand_i[k].strb;
    assign operand_i[k].ready = fire;
  end

  always_comb begin
    join_strb = '1;
    for (int k = 0; k < NB_OPERANDS; k++) begin
      join_strb &= op_strb[k];
    end
  end

  // Per-lane fold chain: acc[k] = op(acc[k-1], operand k)
  for (genvar l = 0; l < NB_LANES; l++) begin : g_lane
    logic [ELEM_WIDTH-1:0] acc [NB_OPERANDS];
    assign acc[0] = op_data[0][l*ELEM_WIDTH +: ELEM_WIDTH];
    for (genvar k = 1; k < NB_OPERANDS; k++) begin : g_fold
      hwpe_stream_vec_alu_lane #(
        .ELEM_WIDTH (ELEM_WIDTH)
      ) u_lane (
        .a   (acc[k-1]),
        .b   (op_data[k][l*ELEM_WIDTH +: ELEM_WIDTH]),
        .op  (op_q),
        .res (acc[k])
      );
    end
    assign join_data[l*ELEM_WIDTH +: ELEM_WIDTH] = acc[NB_OPERANDS-1];
  end

  // Ready chain from the output back: a stage loads when empty or when its successor loads.
  always_comb begin
    stage_load[PIPE_STAGES-1] = ~stage_valid_q[PIPE_STAGES-1] | result_o.ready;
    for (int s = 1; s < PIPE_STAGES; s++) begin
      stage_load[PIPE_STAGES-1-s] = ~stage_valid_q[PIPE_STAGES-1-s] | stage_load[PIPE_STAGES-s];
    end
  end

  always_comb begin
    stage_in_valid[0] = fire;
    stage_in_data[0]  = join_data;
    stage_in_strb[0]  = join_strb;
    for (int s = 1; s < PIPE_STAGES; s++) begin
      stage_in_valid[s] = stage_valid_q[s-1];
      stage_in_data[s]  = stage_data_q[s-1];
      stage_in_strb[s]  = stage_strb_q[s-1];
    end
  end

  always_comb begin
    upstream_valid = 1'b0;
    for (int s = 0; s < int'(PIPE_STAGES) - 1; s++) begin
      upstream_valid |= stage_valid_q[s];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        stage_valid_q[s] <= 1'b0;
        stage_data_q[s]  <= '0;
        stage_strb_q[s]  <= '0;
      end
    end else if (clear_i) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        stage_valid_q[s] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        if (stage_load[s]) begin
          stage_valid_q[s] <= stage_in_valid[s];
          stage_data_q[s]  <= stage_in_data[s];
          stage_strb_q[s]  <= stage_in_strb[s];
        end
      end
    end
  end

  // Ready never looks at clear_i-dropped beats: a beat offered during clear is not taken.
  assign fire      = (state_q == StRun) & (&op_valid) & stage_load[0] & ~clear_i;
  assign last_join = fire & (join_cnt_q == len_q - LEN_WIDTH'(1));
  assign result_hs = stage_valid_q[PIPE_STAGES-1] & result_o.ready;
  // The last beat is the youngest in flight, so its handshake with nothing behind it ends the job.
  assign drain_done = (state_q == StDrain) & result_hs & ~upstream_valid & ~clear_i;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    join_cnt_d  = join_cnt_q;
    count_d     = count_q;
    zero_done_d = 1'b0;
    if (result_hs) begin
      count_d = count_q + LEN_WIDTH'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          count_d = '0;
          if (len_i != '0) begin
            state_d    = StRun;
            op_d       = op_i;
            len_d      = len_i;
            join_cnt_d = '0;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (fire) begin
          join_cnt_d = join_cnt_q + LEN_WIDTH'(1);
          if (last_join) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (drain_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      op_q        <= VEC_OP_ADD;
      len_q       <= '0;
      join_cnt_q  <= '0;
      count_q     <= '0;
      zero_done_q <= 1'b0;
    end else if (clear_i) begin
      state_q     <= StIdle;
      op_q        <= VEC_OP_ADD;
      len_q       <= '0;
      join_cnt_q  <= '0;
      count_q     <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      join_cnt_q  <= join_cnt_d;
      count_q     <= count_d;
      zero_done_q <= zero_done_d;
    end
  end

  assign result_o.valid = stage_valid_q[PIPE_STAGES-1];
  assign result_o.data  = stage_data_q[PIPE_STAGES-1];
  assign result_o.strb  = stage_strb_q[PIPE_STAGES-1];

  assign busy_o  = (state_q != StIdle);
  assign done_o  = zero_done_q | drain_done;
  assign count_o = count_q;

endmodule

// File: tb/tb_hwpe_stream_vec_alu.sv
// Directed bench for hwpe_stream_vec_alu: three instances cover 32-bit lanes with two
// operands, 8-bit lanes with two operands, and 32-bit lanes with three operands.
module tb_hwpe_stream_vec_alu;
  import hwpe_vec_alu_package::*;

  logic clk;
  logic rst;

  int errors = 0;
  int checks = 0;

  // Instance A: E=32, N=2
  logic        a_start, a_clear, a_busy, a_done;
  vec_op_t     a_op;
  logic [15:0] a_len, a_count;
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) opa [2] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) ra ();

  // Instance B: E=8, N=2
  logic        b_start, b_clear, b_busy, b_done;
  vec_op_t     b_op;
  logic [15:0] b_len, b_count;
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) opb [2] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) rb ();

  // Instance C: E=32, N=3
  logic        c_start, c_clear, c_busy, c_done;
  vec_op_t     c_op;
  logic [15:0] c_len, c_count;
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) opc [3] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) rc ();

  hwpe_stream_vec_alu #(
    .DATA_WIDTH(32), .ELEM_WIDTH(32), .NB_OPERANDS(2), .PIPE_STAGES(2), .LEN_WIDTH(16)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .clear_i(a_clear), .start_i(a_start), .op_i(a_op),
    .len_i(a_len), .operand_i(opa), .result_o(ra), .busy_o(a_busy), .done_o(a_done),
    .count_o(a_count)
  );

  hwpe_stream_vec_alu #(
    .DATA_WIDTH(32), .ELEM_WIDTH(8), .NB_OPERANDS(2), .PIPE_STAGES(2), .LEN_WIDTH(16)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .clear_i(b_clear), .start_i(b_start), .op_i(b_op),
    .len_i(b_len), .operand_i(opb), .result_o(rb), .busy_o(b_busy), .done_o(b_done),
    .count_o(b_count)
  );

  hwpe_stream_vec_alu #(
    .DATA_WIDTH(32), .ELEM_WIDTH(32), .NB_OPERANDS(3), .PIPE_STAGES(2), .LEN_WIDTH(16)
  ) dut_c (
    .clk_i(clk), .rst_i(rst), .clear_i(c_clear), .start_i(c_start), .op_i(c_op),
    .len_i(c_len), .operand_i(opc), .result_o(rc), .busy_o(c_busy), .done_o(c_done),
    .count_o(c_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Result beats of instance A, captured mid-cycle.
  logic [31:0] res_a [$];
  always @(negedge clk) begin
    if (ra.valid === 1'b1 && ra.ready === 1'b1) res_a.push_back(ra.data);
  end

  logic [31:0] t1a [4] = '{32'd1, 32'd2, 32'd3, 32'hFFFF_FFFF};
  logic [31:0] t1b [4] = '{32'd10, 32'd20, 32'd30, 32'd1};
  logic [31:0] t1r [4] = '{32'd11, 32'd22, 32'd33, 32'd0};

  vec_op_t     t2_op [8] = '{VEC_OP_MAX_S, VEC_OP_SUB, VEC_OP_MIN_S, VEC_OP_MUL,
                             VEC_OP_ADD, VEC_OP_XOR, VEC_OP_OR, VEC_OP_AND};
  logic [31:0] t2_a  [8] = '{32'h7F80_0102, 32'h0000_0001, 32'h7F80_0102, 32'h10FF_0302,
                             32'hFF01_8001, 32'hF0F0_F0F0, 32'h0F00_0001, 32'hFF00_FF00};
  logic [31:0] t2_b  [8] = '{32'h0081_FF01, 32'h0000_0002, 32'h0081_FF01, 32'h11FF_0503,
                             32'h01FF_8001, 32'hFF00_FF00, 32'h00F0_0010, 32'h0FF0_0FF0};
  logic [3:0]  t2_sa [8] = '{4'hF, 4'hF, 4'h6, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
  logic [3:0]  t2_sb [8] = '{4'hF, 4'hB, 4'hC, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
  logic [31:0] t2_r  [8] = '{32'h7F81_0102, 32'h0000_00FF, 32'h0080_FF01, 32'h1001_0F06,
                             32'h0000_0002, 32'h0FF0_0FF0, 32'h0FF0_0011, 32'h0F00_0F00};
  logic [3:0]  t2_rs [8] = '{4'hF, 4'hB, 4'h4, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One len=1 job on instance B; returns the first result beat seen.
  task automatic run_b(input vec_op_t op, input logic [31:0] da, input logic [31:0] db,
                       input logic [3:0] sa, input logic [3:0] sb,
                       output logic [31:0] d, output logic [3:0] s, output logic ok);
    ok = 1'b0;
    d  = '0;
    s  = '0;
    b_op = op; b_len = 16'd1; b_start = 1'b1; rb.ready = 1'b1;
    cyc();
    b_start = 1'b0;
    opb[0].valid = 1'b1; opb[0].data = da; opb[0].strb = sa;
    opb[1].valid = 1'b1; opb[1].data = db; opb[1].strb = sb;
    cyc();
    opb[0].valid = 1'b0; opb[1].valid = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      #1;
      if (rb.valid === 1'b1) begin
        d  = rb.data;
        s  = rb.strb;
        ok = 1'b1;
      end
      cyc();
    end
  endtask

  int   j, hs, ndone;
  logic rdy, exp_rdy, seen, ok;
  logic [31:0] rd;
  logic [3:0]  rs;

  initial begin
    rst = 1'b1;
    a_start = 0; a_clear = 0; a_op = VEC_OP_ADD; a_len = '0;
    b_start = 0; b_clear = 0; b_op = VEC_OP_ADD; b_len = '0;
    c_start = 0; c_clear = 0; c_op = VEC_OP_ADD; c_len = '0;
    for (int k = 0; k < 1; k++) begin end
    opa[0].valid = 0; opa[0].data = '0; opa[0].strb = '0;
    opa[1].valid = 0; opa[1].data = '0; opa[1].strb = '0;
    opb[0].valid = 0; opb[0].data = '0; opb[0].strb = '0;
    opb[1].valid = 0; opb[1].data = '0; opb[1].strb = '0;
    opc[0].valid = 0; opc[0].data = '0; opc[0].strb = '0;
    opc[1].valid = 0; opc[1].data = '0; opc[1].strb = '0;
    opc[2].valid = 0; opc[2].data = '0; opc[2].strb = '0;
    ra.ready = 0; rb.ready = 0; rc.ready = 0;

    // Reset state
    #12;
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_count", a_count, 0);
    chk("rst_res_valid", ra.valid, 0);
    chk("rst_op_ready", opa[0].ready, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // 1: ADD len=4, wrap in the last beat
    res_a.delete();
    ra.ready = 1; a_op = VEC_OP_ADD; a_len = 16'd4; a_start = 1;
    cyc();
    a_start = 0;
    for (int i = 0; i < 4; i++) begin
      opa[0].valid = 1; opa[0].data = t1a[i]; opa[0].strb = 4'hF;
      opa[1].valid = 1; opa[1].data = t1b[i]; opa[1].strb = 4'hF;
      #1;
      chk("t1_join_ready", {opa[0].ready, opa[1].ready}, 2'b11);
      cyc();
    end
    opa[0].valid = 0; opa[1].valid = 0;
    #1;
    chk("t1_done_early", a_done, 0);
    cyc();
    #1;
    chk("t1_done", a_done, 1);
    chk("t1_busy_drain", a_busy, 1);
    cyc();
    #1;
    chk("t1_done_pulse", a_done, 0);
    chk("t1_busy_idle", a_busy, 0);
    chk("t1_count", a_count, 4);
    chk("t1_nres", res_a.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1_res", res_a[i], t1r[i]);

    // 5: len=0 job
    opa[0].valid = 1; opa[0].data = 32'h55; opa[1].valid = 1; opa[1].data = 32'h66;
    a_len = 16'd0; a_start = 1;
    #1;
    chk("t5_idle_ready", opa[0].ready, 0);
    cyc();
    a_start = 0;
    #1;
    chk("t5_zero_done", a_done, 1);
    chk("t5_zero_busy", a_busy, 0);
    chk("t5_zero_ready", opa[0].ready, 0);
    chk("t5_zero_count", a_count, 0);
    cyc();
    #1;
    chk("t5_zero_done_pulse", a_done, 0);

    // 4: backpressure, len=8 XOR; extra 9th beat offered; start during RUN ignored
    res_a.delete();
    ra.ready = 1; a_op = VEC_OP_XOR; a_len = 16'd8; a_start = 1;
    cyc();
    a_start = 0;
    j = 0; hs = 0; ndone = 0;
    for (int c = 0; c < 60 && ndone == 0; c++) begin
      rdy = (c % 2 == 0);
      ra.ready = rdy;
      opa[0].valid = 1; opa[0].data = j; opa[0].strb = 4'hF;
      opa[1].valid = 1; opa[1].data = 32'h100; opa[1].strb = 4'hF;
      a_start = (c == 3); a_len = 16'd3;
      #1;
      exp_rdy = (j < 8) && (((j - hs) < 2) || rdy);
      chk("t4_op_ready", opa[0].ready, exp_rdy);
      if (a_done === 1'b1) ndone++;
      if (opa[0].ready === 1'b1) j++;
      if (ra.valid === 1'b1 && ra.ready === 1'b1) hs++;
      cyc();
    end
    a_start = 0;
    opa[0].valid = 0; opa[1].valid = 0;
    #1;
    chk("t4_done_seen", ndone, 1);
    chk("t4_joins", j, 8);
    chk("t4_handshakes", hs, 8);
    chk("t4_count", a_count, 8);
    chk("t4_busy", a_busy, 0);
    chk("t4_nres", res_a.size(), 8);
    for (int i = 0; i < 8; i++) chk("t4_res", res_a[i], i ^ 32'h100);

    // 6: clear mid-job after 3 joins, then a fresh len=2 job
    cyc();
    res_a.delete();
    ra.ready = 1; a_op = VEC_OP_ADD; a_len = 16'd10; a_start = 1;
    opa[0].valid = 1; opa[0].data = 32'd1; opa[1].valid = 1; opa[1].data = 32'd2;
    cyc();
    a_start = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_join", opa[0].ready, 1);
      cyc();
    end
    a_clear = 1; ra.ready = 0;
    #1;
    chk("t6_pre_count", a_count, 1);
    chk("t6_clr_ready", opa[0].ready, 0);
    chk("t6_clr_done", a_done, 0);
    cyc();
    a_clear = 0; opa[0].valid = 0; opa[1].valid = 0;
    #1;
    chk("t6_busy", a_busy, 0);
    chk("t6_res_valid", ra.valid, 0);
    chk("t6_count", a_count, 0);
    chk("t6_done", a_done, 0);
    res_a.delete();
    ra.ready = 1; a_len = 16'd2; a_start = 1;
    cyc();
    a_start = 0;
    for (int i = 0; i < 2; i++) begin
      opa[0].valid = 1; opa[0].data = 32'd5 + i; opa[1].valid = 1; opa[1].data = 32'd1;
      #1;
      chk("t6_new_join", opa[0].ready, 1);
      cyc();
    end
    opa[0].valid = 0; opa[1].valid = 0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (a_done === 1'b1) seen = 1;
      cyc();
    end
    chk("t6_new_done", seen, 1);
    chk("t6_new_count", a_count, 2);
    chk("t6_new_nres", res_a.size(), 2);
    chk("t6_new_res0", res_a[0], 32'd6);
    chk("t6_new_res1", res_a[1], 32'd7);

    // 2: 8-bit lanes, all ops, strobe AND
    for (int i = 0; i < 8; i++) begin
      run_b(t2_op[i], t2_a[i], t2_b[i], t2_sa[i], t2_sb[i], rd, rs, ok);
      chk("t2_valid", ok, 1);
      chk("t2_data", rd, t2_r[i]);
      chk("t2_strb", rs, t2_rs[i]);
    end
    chk("t2_count", b_count, 1);
    chk("t2_busy", b_busy, 0);

    // 3: three operands, staggered valids, MUL fold
    rc.ready = 1; c_op = VEC_OP_MUL; c_len = 16'd1; c_start = 1;
    cyc();
    c_start = 0;
    opc[0].data = 32'd3; opc[0].strb = 4'hF;
    opc[1].data = 32'd5; opc[1].strb = 4'hF;
    opc[2].data = 32'd7; opc[2].strb = 4'h7;
    for (int c = 0; c < 4; c++) begin
      opc[0].valid = 1; opc[1].valid = (c >= 1); opc[2].valid = (c >= 3);
      #1;
      chk("t3_ready", {opc[0].ready, opc[1].ready, opc[2].ready}, (c == 3) ? 3'b111 : 3'b000);
      cyc();
    end
    opc[0].valid = 0; opc[1].valid = 0; opc[2].valid = 0;
    #1;
    chk("t3_valid_early", rc.valid, 0);
    cyc();
    #1;
    chk("t3_valid", rc.valid, 1);
    chk("t3_data", rc.data, 32'd105);
    chk("t3_strb", rc.strb, 4'h7);
    chk("t3_done", c_done, 1);
    cyc();
    #1;
    chk("t3_count", c_count, 1);
    chk("t3_busy", c_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
